lr35902_irq: RTL and testbench

- Interrupt controller for the LR35902 core. It sits directly downstream of the timer, serial, joypad and video blocks and consumes their irq outputs.
- Holds the IF (0xFF0F) and IE (0xFFFF) registers.
- Edge-detects the request lines and presents the highest-priority enabled pending request to the CPU.
- Runs a level ack handshake with the CPU: returns the dispatch vector and clears the serviced IF bit exactly once.

---
 rtl/lr35902_irq_pkg.sv | 28 ++
 rtl/lr35902_irq_prio.sv | 20 ++
 rtl/lr35902_irq.sv | 88 ++++++++
 tb/tb_lr35902_irq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lr35902_irq_pkg.sv
// Shared definitions for the LR35902 interrupt controller: source indices,
// register selects, FSM encoding and the vector arithmetic.
package lr35902_irq_pkg;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic ADR_IF = 1'b0;
  localparam logic ADR_IE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } irq_state_e;

  // Dispatch address of source idx; stays within 8 bits for the default layout.
  function automatic logic [7:0] irq_vector(input logic [7:0] base,
                                            input int         stride,
                                            input logic [2:0] idx);
    logic [7:0] step;
    step = 8'(stride);
    return base + step * {5'd0, idx};
  endfunction

endpackage

// File: rtl/lr35902_irq_prio.sv
// Lowest-set-bit priority encoder over the pending interrupt mask.
// Shared with the CPU's HALT/wake logic.
module lr35902_irq_prio #(
  parameter int NSRC = 5
) (
  input  logic [NSRC-1:0] pend,
  output logic            any,
  output logic [2:0]      idx
);

  always_comb begin
    any = |pend;
    idx = 3'd0;
    // Scan downward so the lowest set bit is the last to assign idx.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lr35902_irq.sv
// LR35902 interrupt controller: IF/IE registers, rising-edge capture of the
// peripheral request lines and a two-state level acknowledge with the CPU.
module lr35902_irq
  import lr35902_irq_pkg::*;
#(
  parameter int         NSRC       = 5,
  parameter logic [7:0] VEC_BASE   = 8'h40,
  parameter int         VEC_STRIDE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            adr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  input  logic            read,
  input  logic            write,
  output logic            int_req,
  input  logic            int_ack,
  output logic [7:0]      int_vec
);

  irq_state_e      state, state_d;
  logic [NSRC-1:0] if_q, src_prev, rise;
  logic [NSRC-1:0] if_base, if_clr, if_d;
  logic [NSRC-1:0] pend, pend_ack;
  logic [7:0]      ie_q, ie_eff;
  logic            take;
  logic            ack_any;
  logic [2:0]      ack_idx;

  assign rise = src & ~src_prev;
  assign pend = if_q & ie_q[NSRC-1:0];

  // The dispatch decision sees this cycle's software writes, so a request
  // withdrawn in the ack cycle produces the null vector.
  assign if_base  = (write && adr == ADR_IF) ? din[NSRC-1:0] : if_q;
  assign ie_eff   = (write && adr == ADR_IE) ? din : ie_q;
  assign pend_ack = if_base & ie_eff[NSRC-1:0];

  lr35902_irq_prio #(.NSRC(NSRC)) u_prio (
    .pend (pend_ack),
    .any  (ack_any),
    .idx  (ack_idx)
  );

  assign if_clr = (take && ack_any) ? ({{(NSRC-1){1'b0}}, 1'b1} << ack_idx)
                                    : '0;
  // New edges are ORed in last so they beat a same-cycle clear.
  assign if_d = (if_base & ~if_clr) | rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (int_ack)  state_d = ST_ACK;
      ST_ACK:  if (!int_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    take    = (state == ST_IDLE) && int_ack;
    int_req = (state == ST_IDLE) && (|pend);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_q     <= '0;
      ie_q     <= 8'h00;
      src_prev <= '0;
      dout     <= 8'h00;
      int_vec  <= 8'h00;
    end else begin
      if_q     <= if_d;
      src_prev <= src;
      if (write && adr == ADR_IE) ie_q <= din;
      if (read) dout <= (adr == ADR_IE) ? ie_q : {{(8-NSRC){1'b1}}, if_q};
      if (take) int_vec <= ack_any ? irq_vector(VEC_BASE, VEC_STRIDE, ack_idx)
                                   : 8'h00;
    end
  end

endmodule

// File: tb/tb_lr35902_irq.sv
// Bench for lr35902_irq: directed scenarios plus a randomized run against a
// behavioural model of the IF/IE/ack rules.
module tb_lr35902_irq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] src = '0;
  logic       adr = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic       int_req;
  logic       int_ack = 1'b0;
  logic [7:0] int_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [4:0] m_if, m_prev;
  logic [7:0] m_ie, m_vec, m_dout;
  bit         m_in_ack;

  always #5 clk = ~clk;

  lr35902_irq dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .adr     (adr),
    .din     (din),
    .dout    (dout),
    .read    (read),
    .write   (write),
    .int_req (int_req),
    .int_ack (int_ack),
    .int_vec (int_vec)
  );

  function automatic int lowest_bit(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit model_req();
    return !m_in_ack && ((m_if & m_ie[4:0]) != 5'd0);
  endfunction

  task automatic model_reset();
    m_if = '0; m_prev = '0; m_ie = '0; m_vec = '0; m_dout = '0; m_in_ack = 0;
  endtask

  // Advance one clock; model computes from the inputs held across the edge.
  task automatic step();
    logic [4:0] n_if, p;
    logic [7:0] n_ie, n_vec, n_dout;
    bit         n_in_ack;
    int         k;
    n_if = (write && !adr) ? din[4:0] : m_if;
    n_ie = (write && adr) ? din : m_ie;
    n_dout = read ? (adr ? m_ie : {3'b111, m_if}) : m_dout;
    n_vec = m_vec;
    n_in_ack = m_in_ack;
    if (!m_in_ack && int_ack) begin
      p = n_if & n_ie[4:0];
      k = lowest_bit(p);
      if (k >= 0) begin
        n_vec = 8'(64 + 8 * k);
        n_if[k] = 1'b0;
      end else begin
        n_vec = 8'h00;
      end
      n_in_ack = 1;
    end else if (m_in_ack && !int_ack) begin
      n_in_ack = 0;
    end
    n_if = n_if | (src & ~m_prev);
    @(posedge clk);
    m_if = n_if; m_ie = n_ie; m_vec = n_vec; m_dout = n_dout;
    m_in_ack = n_in_ack; m_prev = src;
    #1;
  endtask

  task automatic do_write(input logic a, input logic [7:0] d);
    write = 1'b1; adr = a; din = d;
    step();
    write = 1'b0;
  endtask

  task automatic do_read(input logic a);
    read = 1'b1; adr = a;
    step();
    read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (int_req !== 1'b0 || int_vec !== 8'h00 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got req=%b vec=%h dout=%h exp 0 00 00", int_req, int_vec, dout);
    end
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE0) begin errors++; $display("FAIL reset_if got %h exp e0", dout); end
    do_read(1'b1);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_ie got %h exp 00", dout); end
  endtask

  task automatic test_timer_pulse();
    do_write(1'b1, 8'h04);
    src = 5'b00100; step(); src = '0;
    checks++;
    if (int_req !== 1'b1) begin errors++; $display("FAIL timer_req got %b exp 1", int_req); end
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE4) begin errors++; $display("FAIL timer_if_set got %h exp e4", dout); end
    int_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (int_vec !== 8'h50 || int_req !== 1'b0) begin
        errors++;
        $display("FAIL timer_ack cyc %0d got vec=%h req=%b exp 50 0", i, int_vec, int_req);
      end
    end
    int_ack = 1'b0;
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE0 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL timer_if_clear got dout=%h req=%b exp e0 0", dout, int_req);
    end
  endtask

  task automatic test_two_sources();
    do_write(1'b1, 8'h1F);
    src = 5'b10010; step(); src = '0;
    checks++;
    if (int_req !== 1'b1) begin errors++; $display("FAIL two_req got %b exp 1", int_req); end
    int_ack = 1'b1; step();
    checks++;
    if (int_vec !== 8'h48) begin errors++; $display("FAIL two_first_vec got %h exp 48", int_vec); end
    int_ack = 1'b0; step();
    do_read(1'b0);
    checks++;
    if (dout !== 8'hF0) begin errors++; $display("FAIL two_first_if got %h exp f0", dout); end
    int_ack = 1'b1; step();
    checks++;
    if (int_vec !== 8'h60) begin errors++; $display("FAIL two_second_vec got %h exp 60", int_vec); end
    int_ack = 1'b0; step();
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE0) begin errors++; $display("FAIL two_second_if got %h exp e0", dout); end
  endtask

  task automatic test_held_level();
    int dispatches = 0;
    do_write(1'b1, 8'h02);
    src = 5'b00010;
    for (int i = 0; i < 20; i++) begin
      int_ack = (i == 3);
      step();
      if (i == 3) begin
        checks++;
        if (int_vec !== 8'h48) begin errors++; $display("FAIL held_vec got %h exp 48", int_vec); end
      end
      if (int_req === 1'b1) dispatches++;
    end
    int_ack = 1'b0;
    checks++;
    if (dispatches !== 3) begin
      errors++;
      $display("FAIL held_req_cycles got %0d exp 3", dispatches);
    end
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE0 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL held_if_stays_clear got dout=%h req=%b exp e0 0", dout, int_req);
    end
    src = '0; step();
    src = 5'b00010; step();
    src = '0;
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE2) begin errors++; $display("FAIL held_reedge got %h exp e2", dout); end
  endtask

  task automatic test_clear_race();
    do_write(1'b1, 8'h04);
    write = 1'b1; adr = 1'b0; din = 8'h00; src = 5'b00100;
    step();
    write = 1'b0; src = '0;
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE4) begin errors++; $display("FAIL race_edge_wins got %h exp e4", dout); end
    checks++;
    if (int_req !== 1'b1) begin errors++; $display("FAIL race_req got %b exp 1", int_req); end
    write = 1'b1; adr = 1'b0; din = 8'h00; int_ack = 1'b1;
    step();
    write = 1'b0;
    checks++;
    if (int_vec !== 8'h00) begin errors++; $display("FAIL race_null_vec got %h exp 00", int_vec); end
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE0) begin errors++; $display("FAIL race_if got %h exp e0", dout); end
    int_ack = 1'b0; step();
  endtask

  task automatic test_reset_mid_ack();
    do_write(1'b1, 8'h04);
    src = 5'b00100; step(); src = '0;
    int_ack = 1'b1; step(); step();
    checks++;
    if (int_vec !== 8'h50) begin errors++; $display("FAIL midack_vec got %h exp 50", int_vec); end
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (int_vec !== 8'h00 || dout !== 8'h00 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL midack_async got vec=%h dout=%h req=%b exp 00 00 0", int_vec, dout, int_req);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    checks++;
    if (int_vec !== 8'h00) begin errors++; $display("FAIL midack_null got %h exp 00", int_vec); end
    do_read(1'b0);
    checks++;
    if (dout !== 8'hE0) begin errors++; $display("FAIL midack_if got %h exp e0", dout); end
    do_read(1'b1);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL midack_ie got %h exp 00", dout); end
    int_ack = 1'b0; step();
    checks++;
    if (int_req !== 1'b0) begin errors++; $display("FAIL midack_req got %b exp 0", int_req); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      src   = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      write = ($urandom_range(0, 7) == 0);
      read  = ($urandom_range(0, 1) == 1);
      adr   = 1'($urandom_range(0, 1));
      din   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) int_ack = ~int_ack;
      step();
      checks++;
      if (dout !== m_dout || int_vec !== m_vec || int_req !== model_req()) begin
        errors++;
        $display("FAIL random cyc %0d got dout=%h vec=%h req=%b exp %h %h %b",
                 i, dout, int_vec, int_req, m_dout, m_vec, model_req());
      end
    end
    write = 1'b0; read = 1'b0; int_ack = 1'b0; src = '0;
  endtask

  initial begin
    test_reset();
    test_timer_pulse();
    test_two_sources();
    test_held_level();
    test_clear_race();
    test_reset_mid_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
